// File: rtl/alu_issue.sv
// alu_issue: FIFO-buffered command front-end that issues one op at a time to a multi-cycle ALU
// and returns its result (or a timeout/illegal-mode error) with the request tag.
module alu_issue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_mode,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     alu_valid,
    output logic [3:0]               alu_mode,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    input  logic                     alu_ready,
    input  logic [63:0]              alu_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [63:0]              rsp_data,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_nx;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] timer;
    logic [3:0] fifo_mode [DEPTH];
    logic [31:0] fifo_a [DEPTH];
    logic [31:0] fifo_b [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic push, pop, head_ok, timeout;

    assign cmd_ready = count != CW'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == IDLE && count != '0;
    assign head_ok   = fifo_mode[rd_ptr] <= 4'd10;
    assign timeout   = timer == TW'(TIMEOUT - 1);
    assign alu_valid = state == ISSUE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE || count != '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pop ? (head_ok ? ISSUE : RESP) : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (alu_ready || timeout) ? RESP : WAIT;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Storage is not reset: the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mode[wr_ptr] <= cmd_mode;
            fifo_a[wr_ptr]    <= cmd_a;
            fifo_b[wr_ptr]    <= cmd_b;
            fifo_tag[wr_ptr]  <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            timer    <= '0;
            alu_mode <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                rsp_tag <= fifo_tag[rd_ptr];
                if (head_ok) begin
                    alu_mode <= fifo_mode[rd_ptr];
                    alu_a    <= fifo_a[rd_ptr];
                    alu_b    <= fifo_b[rd_ptr];
                end else begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == ISSUE)
                timer <= '0;
            // A ready pulse outside WAIT never reaches the response registers.
            if (state == WAIT) begin
                if (alu_ready) begin
                    rsp_data <= alu_data;
                    rsp_err  <= 1'b0;
                end else if (timeout) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end
endmodule
